// File: rtl/bounce_sprites.sv
// bounce_sprites: NSPR bouncing sprites with shared speed control and sound events.
// Define SPRITE_COLLIDE_EN to make overlapping sprites reverse dx at the next frame tick.
module bounce_sprites #(
   parameter int NSPR  = 2,
   parameter int SPR_W = 80,
   parameter int SPR_H = 96,
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int VMAX  = 7
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [9:0] x_px,
   input  logic [9:0] y_px,
   input  logic       inc_vel,
   input  logic       dec_vel,
   output logic [2:0] color_px,
   output logic       mute,
   output logic [1:0] code_sound,
   output logic       snd_stb
);
   localparam logic signed [10:0] XMAX = 11'(H_RES - SPR_W);
   localparam logic signed [10:0] YMAX = 11'(V_RES - SPR_H);
   localparam logic signed [10:0] SW   = 11'(SPR_W);
   localparam logic signed [10:0] SH   = 11'(SPR_H);

   logic signed [10:0] r_x [NSPR];
   logic signed [10:0] r_y [NSPR];
   logic [NSPR-1:0]    r_dx, r_dy;
   logic [3:0]         r_vel;
   logic [2:0]         r_inc, r_dec;
   logic               r_go, r_stop;
   logic signed [10:0] w_ax [NSPR];
   logic signed [10:0] w_ay [NSPR];
   logic signed [10:0] w_nx [NSPR];
   logic signed [10:0] w_ny [NSPR];
   logic signed [10:0] w_sv, w_xs, w_ys;
   logic [NSPR-1:0]    w_flip, w_dxe, w_px, w_py, w_cov;
   logic               w_tick, w_inc, w_dec, w_ping, w_pong, w_snd;
   logic [3:0]         w_vel;
   logic [2:0]         w_col;

`ifdef SPRITE_COLLIDE_EN
   logic [NSPR-1:0]    r_hit;
   assign w_flip = r_hit;
`else
   assign w_flip = '0;
`endif

   assign w_tick = x_px == 10'd0 && y_px == 10'(V_RES);
   assign w_sv   = signed'({7'd0, r_vel});
   assign w_xs   = signed'({1'b0, x_px});
   assign w_ys   = signed'({1'b0, y_px});
   // r_inc/r_dec: [0],[1] synchroniser, [2] previous value for edge detect
   assign w_inc  = r_inc[1] & ~r_inc[2];
   assign w_dec  = r_dec[1] & ~r_dec[2];
   assign w_vel  = w_inc && !w_dec && r_vel != 4'(VMAX) ? r_vel + 4'd1 :
                   w_dec && !w_inc && r_vel != 4'd0    ? r_vel - 4'd1 : r_vel;
   assign w_ping = w_tick && (|w_px || |w_flip);
   assign w_pong = w_tick && |w_py;
   assign w_snd  = r_go || r_stop || w_ping || w_pong;

   always_comb begin
      for (int i = 0; i < NSPR; i++) begin
         w_dxe[i] = r_dx[i] ^ w_flip[i];
         w_ax[i]  = w_dxe[i] ? r_x[i] - w_sv : r_x[i] + w_sv;
         w_ay[i]  = r_dy[i] ? r_y[i] - w_sv : r_y[i] + w_sv;
         w_px[i]  = w_ax[i] < 0 || w_ax[i] > XMAX;
         w_py[i]  = w_ay[i] < 0 || w_ay[i] > YMAX;
         w_nx[i]  = w_ax[i] < 0 ? 11'sd0 : w_ax[i] > XMAX ? XMAX : w_ax[i];
         w_ny[i]  = w_ay[i] < 0 ? 11'sd0 : w_ay[i] > YMAX ? YMAX : w_ay[i];
         w_cov[i] = x_px < 10'(H_RES) && y_px < 10'(V_RES) &&
                    w_xs >= r_x[i] && w_xs < r_x[i] + SW &&
                    w_ys >= r_y[i] && w_ys < r_y[i] + SH;
      end
   end

   // walk downwards so the lowest covering index has the final say
   always_comb begin
      w_col = 3'd0;
      for (int i = NSPR - 1; i >= 0; i--) w_col = w_cov[i] ? 3'(i % 7 + 1) : w_col;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < NSPR; i++) begin
            r_x[i]  <= 11'(i * 2 * SPR_W);
            r_y[i]  <= 11'((V_RES - SPR_H) / 2);
            r_dy[i] <= 1'(i % 2);
         end
         r_dx       <= '0;
         r_vel      <= 4'd1;
         r_inc      <= '0;
         r_dec      <= '0;
         r_go       <= 1'b0;
         r_stop     <= 1'b0;
         mute       <= 1'b0;
         code_sound <= 2'b00;
         snd_stb    <= 1'b0;
         color_px   <= 3'd0;
`ifdef SPRITE_COLLIDE_EN
         r_hit      <= '0;
`endif
      end else begin
         r_inc    <= {r_inc[1:0], inc_vel};
         r_dec    <= {r_dec[1:0], dec_vel};
         r_vel    <= w_vel;
         mute     <= w_vel == 4'd0;
         r_go     <= r_vel == 4'd0 && w_vel == 4'd1;
         r_stop   <= r_vel == 4'd1 && w_vel == 4'd0;
         snd_stb  <= w_snd;
         color_px <= w_col;
         if (w_snd) code_sound <= r_stop ? 2'b11 : r_go ? 2'b10 : w_ping ? 2'b00 : 2'b01;
         if (w_tick) begin
            for (int i = 0; i < NSPR; i++) begin
               r_x[i] <= w_nx[i];
               r_y[i] <= w_ny[i];
            end
            r_dx <= w_dxe ^ w_px;
            r_dy <= r_dy ^ w_py;
         end
`ifdef SPRITE_COLLIDE_EN
         r_hit <= w_tick ? '0 : r_hit | ($countones(w_cov) > 1 ? w_cov : '0);
`endif
      end
   end
endmodule

// File: tb/tb_bounce_sprites.sv
// tb_bounce_sprites: directed checks of bounce_sprites at default size plus a small
// 320x120 instance where both sprites always share scanlines, used for the overlap case.
module tb_bounce_sprites;
   logic       clk = 1'b0, clr = 1'b0, inc_vel = 1'b0, dec_vel = 1'b0;
   logic [9:0] x_px = 10'd0, y_px = 10'd481, x2 = 10'd0, y2 = 10'd121;
   logic [2:0] color_px, color2;
   logic       mute, mute2, snd_stb, stb2;
   logic [1:0] code_sound, code2;
   int         checks = 0, failures = 0, cnt;

`ifdef SPRITE_COLLIDE_EN
   localparam int S0X = 120, S1X = 201, CSTB = 1;
`else
   localparam int S0X = 122, S1X = 199, CSTB = 0;
`endif

   always #5 clk = ~clk;

   bounce_sprites dut (
      .clk(clk), .clr(clr), .x_px(x_px), .y_px(y_px), .inc_vel(inc_vel), .dec_vel(dec_vel),
      .color_px(color_px), .mute(mute), .code_sound(code_sound), .snd_stb(snd_stb)
   );

   bounce_sprites #(.H_RES(320), .V_RES(120)) dut2 (
      .clk(clk), .clr(clr), .x_px(x2), .y_px(y2), .inc_vel(inc_vel), .dec_vel(dec_vel),
      .color_px(color2), .mute(mute2), .code_sound(code2), .snd_stb(stb2)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic px(input string tag, input int x, input int y, input int exp);
      x_px = 10'(x);
      y_px = 10'(y);
      step();
      chk(tag, 32'(color_px), 32'(exp));
      x_px = 10'd0;
      y_px = 10'd481;
   endtask

   task automatic px2(input string tag, input int x, input int y, input int exp);
      x2 = 10'(x);
      y2 = 10'(y);
      step();
      chk(tag, 32'(color2), 32'(exp));
      x2 = 10'd0;
      y2 = 10'd121;
   endtask

   task automatic tick();
      x_px = 10'd0;
      y_px = 10'd480;
      step();
      y_px = 10'd481;
   endtask

   task automatic tick2();
      x2 = 10'd0;
      y2 = 10'd120;
      step();
      y2 = 10'd121;
   endtask

   task automatic pulse_inc();
      inc_vel = 1'b1;
      step(3);
      inc_vel = 1'b0;
      step(4);
   endtask

   task automatic pulse_dec();
      dec_vel = 1'b1;
      step(3);
      dec_vel = 1'b0;
      step(4);
   endtask

   initial begin
      step(2);
      chk("rst_color", 32'(color_px), 0);
      chk("rst_mute", 32'(mute), 0);
      chk("rst_stb", 32'(snd_stb), 0);
      chk("rst_code", 32'(code_sound), 0);
      clr = 1'b1;
      step();
      px("s0_inside", 5, 200, 1);
      px("s1_inside", 170, 200, 2);
      px("background", 300, 10, 0);
      px("s0_topleft", 0, 192, 1);
      px("s0_botright", 79, 287, 1);
      px("gap_x80", 80, 192, 0);
      px("s1_below", 160, 288, 0);
      repeat (121) tick2();
      px2("overlap_color", 200, 50, 1);
      tick2();
      chk("collide_stb", 32'(stb2), 32'(CSTB));
      if (stb2) chk("collide_code", 32'(code2), 0);
      step();
      chk("collide_stb_once", 32'(stb2), 0);
      px2("c_s0_left", S0X, 15, 1);
      px2("c_s0_before", S0X - 1, 15, 0);
      px2("c_s1_right", S1X + 79, 50, 2);
      px2("c_s1_after", S1X + 80, 50, 0);
      tick();
      chk("tick1_nostb", 32'(snd_stb), 0);
      px("t1_s0", 1, 193, 1);
      px("t1_s0_left", 0, 193, 0);
      px("t1_s0_above", 1, 192, 0);
      px("t1_s1", 161, 191, 2);
      px("t1_s1_left", 160, 191, 0);
      pulse_inc();
      pulse_inc();
      repeat (186) tick();
      tick();
      chk("ping_stb", 32'(snd_stb), 1);
      chk("ping_code", 32'(code_sound), 0);
      step();
      chk("ping_once", 32'(snd_stb), 0);
      px("clamp_x560", 560, 15, 1);
      px("clamp_x559", 559, 15, 0);
      px("clamp_corner", 639, 110, 1);
      px("clamp_below", 560, 111, 0);
      tick();
      px("back_x557", 557, 12, 1);
      px("back_x556", 556, 12, 0);
      pulse_dec();
      pulse_dec();
      dec_vel = 1'b1;
      step(3);
      dec_vel = 1'b0;
      chk("stop_mute", 32'(mute), 1);
      chk("stop_early", 32'(snd_stb), 0);
      step();
      chk("stop_stb", 32'(snd_stb), 1);
      chk("stop_code", 32'(code_sound), 3);
      step();
      chk("stop_once", 32'(snd_stb), 0);
      step(4);
      tick();
      chk("vel0_nowall", 32'(snd_stb), 0);
      px("vel0_hold", 557, 12, 1);
      px("vel0_hold_left", 556, 12, 0);
      inc_vel = 1'b1;
      step(3);
      inc_vel = 1'b0;
      chk("go_unmute", 32'(mute), 0);
      step();
      chk("go_stb", 32'(snd_stb), 1);
      chk("go_code", 32'(code_sound), 2);
      step();
      chk("go_once", 32'(snd_stb), 0);
      step(4);
      inc_vel = 1'b1;
      cnt = 0;
      repeat (10) begin
         step();
         cnt += int'(snd_stb);
      end
      inc_vel = 1'b0;
      step(4);
      chk("hold_nostb", 32'(cnt), 0);
      tick();
      px("vel2_x555", 555, 10, 1);
      px("vel2_x554", 554, 10, 0);
      pulse_inc();
      pulse_inc();
      inc_vel = 1'b1;
      dec_vel = 1'b1;
      cnt = 0;
      repeat (8) begin
         step();
         cnt += int'(snd_stb);
      end
      inc_vel = 1'b0;
      dec_vel = 1'b0;
      step(4);
      chk("both_nostb", 32'(cnt), 0);
      tick();
      px("vel4_x551", 551, 6, 1);
      px("vel4_x550", 550, 6, 0);
      x_px = 10'd600;
      y_px = 10'd50;
      step();
      chk("pre_clr_color", 32'(color_px), 1);
      clr = 1'b0;
      #1;
      chk("clr_color", 32'(color_px), 0);
      chk("clr_stb", 32'(snd_stb), 0);
      step();
      x_px = 10'd0;
      y_px = 10'd481;
      clr = 1'b1;
      step();
      chk("clr_mute", 32'(mute), 0);
      px("clr_s0", 5, 200, 1);
      px("clr_s1", 170, 200, 2);
      tick();
      chk("clr_tick_nostb", 32'(snd_stb), 0);
      px("clr_t1_s0", 1, 193, 1);
      px("clr_t1_s0_left", 0, 193, 0);
      px("clr_t1_s1", 161, 191, 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bounce_sprites.md
# bounce_sprites

Parametrised multi-sprite bouncing-logo engine for the VGA pong screen. It moves NSPR rectangular sprites once per video frame, bounces them off the screen borders, and renders them into the pixel colour stream. It also handles the shared speed control (inc/dec) and drives the sound generator with event codes. It sits between the VGA sync counters (x_px/y_px) and the colour mixer/sound block, replacing the single-logo top.

## Interface
- NSPR, 2: number of sprites, 1..8
- SPR_W, 80: sprite width in pixels
- SPR_H, 96: sprite height in pixels
- H_RES, 640: visible width
- V_RES, 480: visible height
- VMAX, 7: maximum speed level (pixels/frame), 1..15

- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-low
- x_px  in  10  current pixel column
- y_px  in  10  current pixel row
- inc_vel  in  1  increase speed (level, any duration)
- dec_vel  in  1  decrease speed (level, any duration)
- color_px  out  3  pixel colour, 0 = background
- mute  out  1  high while speed level is 0
- code_sound  out  2  00 ping (left/right wall), 01 pong (top/bottom wall), 10 go, 11 stop
- snd_stb  out  1  one-cycle strobe, code_sound valid

## Operation
- Reset (clr=0):
  - vel=1.
  - Sprite i: x=i·2·SPR_W, y=(V_RES−SPR_H)/2, dx=+1, dy=+1 for even i, −1 for odd i.
  - color_px=0, mute=0, code_sound=00, snd_stb=0.
  - Constraint: NSPR·2·SPR_W ≤ H_RES.
- Frame tick: asserted for the single cycle where x_px==0 && y_px==V_RES.
- Motion on the tick:
  - Each sprite computes nx = x ± vel and ny = y ± vel in 11-bit signed arithmetic.
  - If nx<0 or nx>H_RES−SPR_W: clamp to the bound, invert dx, raise a ping event.
  - Y uses the same rule with V_RES−SPR_H, raising a pong event.
  - A corner hit inverts both directions.
  - vel=0: positions hold, no wall events.
- Speed control:
  - inc_vel/dec_vel pass through a 2-flop synchroniser followed by a rising-edge detector.
  - Inc edge: vel+1, saturating at VMAX. Dec edge: vel−1, saturating at 0.
  - Simultaneous inc and dec edges: no change.
  - Transition 0→1 raises go; 1→0 raises stop.
  - mute = (vel==0), registered.
- Sound arbitration, at most one strobe per cycle: stop/go > ping > pong. Lower sprite index wins ties.
  - Events losing arbitration are dropped, not queued.
- Rendering:
  - Sprite i covers x ≤ x_px < x+SPR_W and y ≤ y_px < y+SPR_H.
  - Colour = (i mod 7)+1. The lowest covering index wins; background is 0.
  - Coordinates outside the visible area give 0.

## Timing
- color_px is registered: 1 cycle latency from x_px/y_px.
- Positions update on the clk edge ending the frame-tick cycle. All sprites update in parallel in that single cycle.
- Wall-event snd_stb fires 1 cycle after the tick.
- go/stop snd_stb fires 1 cycle after the vel register changes, i.e. 4 cycles after the raw input rising edge (2 sync + edge + vel).
- A speed change takes effect at the next frame tick.
- clr asserted mid-frame: all state returns to reset values immediately, with no strobe. After release, the first move occurs at the next tick.

## Configuration
- SPRITE_COLLIDE_EN defined:
  - During the visible scan, any pixel covered by two or more sprites sets a sticky hit bit for every covering sprite.
  - On the next frame tick, each hit sprite inverts dx before moving, and a ping event is raised. All hit bits then clear.
- Undefined: sprites pass through each other and overlap rendering uses index priority only.

## Test plan
- Reset, NSPR=2, default sizes:
  - Sprite 0 at (0,192), sprite 1 at (160,192).
  - Pixel (5,200) → color_px=1 one cycle later; (170,200) → 2; (300,10) → 0.
- Run 1 frame at vel=1 → sprite 0 at (1,193), sprite 1 at (161,191), no snd_stb.
- Force sprite 0 to x=559, dx=+1, vel=3; tick → x=560, dx=−1, snd_stb with code_sound=00 one cycle after the tick.
- From vel=1, pulse dec_vel for 3 cycles:
  - vel=0, mute=1, single strobe code 11.
  - Then pulse inc_vel → vel=1, mute=0, code 10.
  - Hold inc_vel 10 cycles → exactly one increment.
- inc_vel and dec_vel rising together at vel=4 → vel stays 4, no strobe.
- With SPRITE_COLLIDE_EN, two sprites approaching with overlapping scanlines → both dx invert at the next tick, single ping strobe. Without the macro, directions are unchanged and the overlap renders colour 1.
